// File: rtl/bf_pkg.sv
// Shared types and helpers for the partial-sum accumulator: FSM state enum,
// default geometry and a generic sign-extension helper.
package bf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } acc_state_t;

  localparam int unsigned DEF_ARRAY_SIZE = 16;
  localparam int unsigned DEF_COL_WIDTH  = 13;
  localparam int unsigned PSUM_W         = DEF_COL_WIDTH * 4;
  localparam int unsigned COL_IDX_W      = $clog2(DEF_ARRAY_SIZE);
  localparam int unsigned SEXT_W         = 128;

  // Treats the low w bits of v as two's complement and replicates bit w-1 upward.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                             input int unsigned       w);
    logic signed [SEXT_W-1:0] t;
    t = signed'(v << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One accumulator lane: load or add a sign-extended psum; saturates instead of
// wrapping when PSUM_ACC_SAT_EN is defined. ovf_o flags a signed overflow on add.
module psum_acc_lane #(
  parameter int unsigned ACC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 add_i,
  input  logic [ACC_WIDTH-1:0] din_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf;

  assign sum = acc_q + din_i;
  // Overflow only when both operands share a sign the result does not.
  assign ovf = (acc_q[ACC_WIDTH-1] == din_i[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign ovf_o = add_i && !load_i && ovf;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = din_i;
    end else if (add_i) begin
`ifdef PSUM_ACC_SAT_EN
      if (ovf) begin
        acc_d = din_i[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        acc_d = sum;
      end
`else
      acc_d = sum;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cfg_passes rows of per-column psums, then drains one column per cycle.
// Optional PSUM_ACC_SAT_EN: saturating lanes plus a sticky per-tile sat_flag output.
module psum_accumulator
  import bf_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int unsigned COL_WIDTH  = DEF_COL_WIDTH,
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned PASS_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [PASS_W-1:0]                 cfg_passes,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  input  logic [ARRAY_SIZE*COL_WIDTH*4-1:0] psums,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_WIDTH-1:0]              out_data,
  output logic [$clog2(ARRAY_SIZE)-1:0]     out_col,
  output logic                              busy,
  output logic                              done
`ifdef PSUM_ACC_SAT_EN
  ,
  output logic                              sat_flag
`endif
);

  localparam int unsigned PW = COL_WIDTH * 4;
  localparam int unsigned CW = $clog2(ARRAY_SIZE);

  acc_state_t        state_q, state_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CW-1:0]     col_idx_q, col_idx_d;
  logic              done_q, done_d;
  logic              sat_q, sat_d;

  logic                 beat;
  logic [ARRAY_SIZE-1:0] lane_ovf;
  logic [ACC_WIDTH-1:0]  acc [ARRAY_SIZE];

  assign beat = (state_q == ACCUM) && psum_valid;

  // First beat of a tile loads each lane, so no separate clear pass is needed.
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    logic [ACC_WIDTH-1:0] lane_din;
    assign lane_din = ACC_WIDTH'(sext(SEXT_W'(psums[g*PW +: PW]), PW));
    psum_acc_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (beat && (pass_cnt_q == '0)),
      .add_i  (beat && (pass_cnt_q != '0)),
      .din_i  (lane_din),
      .acc_o  (acc[g]),
      .ovf_o  (lane_ovf[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    col_idx_d  = col_idx_q;
    done_d     = 1'b0;
    sat_d      = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          passes_d   = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
          pass_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (psum_valid) begin
          pass_cnt_d = pass_cnt_q + 1'b1;
          if (|lane_ovf) sat_d = 1'b1;
          if (pass_cnt_q + 1'b1 == passes_q) begin
            state_d   = DRAIN;
            col_idx_d = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (col_idx_q == CW'(ARRAY_SIZE - 1)) begin
            state_d   = IDLE;
            col_idx_d = '0;
            done_d    = 1'b1;
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      col_idx_q  <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      col_idx_q  <= col_idx_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  assign psum_ready = (state_q == ACCUM);
  assign out_valid  = (state_q == DRAIN);
  assign out_data   = out_valid ? acc[col_idx_q] : '0;
  assign out_col    = col_idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

`ifdef PSUM_ACC_SAT_EN
  assign sat_flag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator (4 columns; a 52-bit
// accumulator instance covers the wrap/saturate boundary).
module tb_psum_accumulator;

  localparam int unsigned AS = 4;
  localparam int unsigned PW = 52;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [7:0]      cfg_passes;
  logic            psum_valid;
  logic            psum_ready;
  logic [AS*PW-1:0] psums;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_data;
  logic [1:0]      out_col;
  logic            busy;
  logic            done;

  logic            start2;
  logic [7:0]      cfg_passes2;
  logic            psum_valid2;
  logic            psum_ready2;
  logic [AS*PW-1:0] psums2;
  logic            out_valid2;
  logic            out_ready2;
  logic [51:0]     out_data2;
  logic [1:0]      out_col2;
  logic            busy2;
  logic            done2;
`ifdef PSUM_ACC_SAT_EN
  logic            sat_flag;
  logic            sat_flag2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psum_accumulator #(
    .ARRAY_SIZE(AS), .COL_WIDTH(13), .ACC_WIDTH(64), .PASS_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_passes(cfg_passes),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psums(psums),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .busy(busy), .done(done)
`ifdef PSUM_ACC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  psum_accumulator #(
    .ARRAY_SIZE(AS), .COL_WIDTH(13), .ACC_WIDTH(52), .PASS_W(8)
  ) u_dut52 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cfg_passes(cfg_passes2),
    .psum_valid(psum_valid2), .psum_ready(psum_ready2), .psums(psums2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_col(out_col2), .busy(busy2), .done(done2)
`ifdef PSUM_ACC_SAT_EN
    , .sat_flag(sat_flag2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AS*PW-1:0] pack4(input longint c0, input longint c1,
                                             input longint c2, input longint c3);
    return {PW'(c3), PW'(c2), PW'(c1), PW'(c0)};
  endfunction

  task automatic start_tile(input string tag, input logic [7:0] p);
    start = 1'b1;
    cfg_passes = p;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_done_low"}, 64'(done), 64'd0);
    chk({tag, "_psum_ready"}, 64'(psum_ready), 64'd1);
  endtask

  task automatic beat(input logic [AS*PW-1:0] v);
    psum_valid = 1'b1;
    psums = v;
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic drain_all(input string tag, input longint e0, input longint e1,
                           input longint e2, input longint e3);
    longint e [4];
    e = '{e0, e1, e2, e3};
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_valid%0d", tag, c), 64'(out_valid), 64'd1);
      chk($sformatf("%s_col%0d", tag, c), 64'(out_col), 64'(c));
      chk($sformatf("%s_data%0d", tag, c), out_data, e[c]);
      chk($sformatf("%s_pready%0d", tag, c), 64'(psum_ready), 64'd0);
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_valid_low"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_passes = '0; psum_valid = 1'b0;
    psums = '0; out_ready = 1'b0;
    start2 = 1'b0; cfg_passes2 = '0; psum_valid2 = 1'b0; psums2 = '0; out_ready2 = 1'b0;
    tick(); tick();
    chk("rst_pready", 64'(psum_ready), 64'd0);
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_odata", out_data, 64'd0);
    chk("rst_ocol", 64'(out_col), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single pass; psum_valid ignored in IDLE
    psum_valid = 1'b1; psums = pack4(99, 99, 99, 99);
    tick();
    chk("idle_ignore_busy", 64'(busy), 64'd0);
    chk("idle_ignore_pready", 64'(psum_ready), 64'd0);
    psum_valid = 1'b0;
    start_tile("t1", 8'd1);
    beat(pack4(1, 2, 3, 4));
    drain_all("t1", 1, 2, 3, 4);
    tick();
    chk("t1_done_once", 64'(done), 64'd0);

    // Multi-pass signed with 2-cycle gaps; start coincides with nothing else
    start_tile("t2", 8'd3);
    beat(pack4(5, -(longint'(1) << 51), 0, 1));
    tick(); tick();
    chk("t2_gap_pready", 64'(psum_ready), 64'd1);
    chk("t2_gap_ovalid", 64'(out_valid), 64'd0);
    beat(pack4(-7, -(longint'(1) << 51), 0, 1));
    tick(); tick();
    chk("t2_gap2_pready", 64'(psum_ready), 64'd1);
    beat(pack4(100, -(longint'(1) << 51), 0, 1));
    drain_all("t2", 98, -3 * (longint'(1) << 51), 0, 3);
`ifdef PSUM_ACC_SAT_EN
    chk("t2_satflag", 64'(sat_flag), 64'd0);
`endif

    // cfg_passes=0 acts as 1; start in the done cycle is honoured
    start_tile("t3", 8'd0);
    tick(); tick();
    chk("t3_gap_pready", 64'(psum_ready), 64'd1);
    chk("t3_gap_ovalid", 64'(out_valid), 64'd0);
    beat(pack4(10, -1, 0, 7));
    drain_all("t3", 10, -1, 0, 7);
    tick();

    // Back-pressure on col2 with an ignored start during DRAIN
    start_tile("t4", 8'd1);
    beat(pack4(11, 22, 33, 44));
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      start = (s == 2);
      cfg_passes = 8'd1;
      chk($sformatf("t4_hold_col%0d", s), 64'(out_col), 64'd2);
      chk($sformatf("t4_hold_data%0d", s), out_data, 64'd33);
      chk($sformatf("t4_hold_valid%0d", s), 64'(out_valid), 64'd1);
      chk($sformatf("t4_hold_pready%0d", s), 64'(psum_ready), 64'd0);
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("t4_col2", 64'(out_col), 64'd2);
    chk("t4_data2", out_data, 64'd33);
    tick();
    chk("t4_data3", out_data, 64'd44);
    tick();
    out_ready = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    tick();
    chk("t4_idle_after", 64'(busy), 64'd0);

    // Reset mid-DRAIN aborts, next tile is clean
    start_tile("t5", 8'd1);
    beat(pack4(5, 6, 7, 8));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ovalid", 64'(out_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ocol", 64'(out_col), 64'd0);
    chk("t5_rst_pready", 64'(psum_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_tile("t6", 8'd2);
    beat(pack4(1, 1, 1, 1));
    beat(pack4(2, 2, 2, 2));
    drain_all("t6", 3, 3, 3, 3);

    // 52-bit accumulator boundary: 2 x (2^51-1)
    start2 = 1'b1; cfg_passes2 = 8'd2;
    tick();
    start2 = 1'b0;
    psum_valid2 = 1'b1;
    psums2 = pack4((longint'(1) << 51) - 1, 0, 0, 0);
    tick(); tick();
    psum_valid2 = 1'b0;
    chk("w52_valid", 64'(out_valid2), 64'd1);
`ifdef PSUM_ACC_SAT_EN
    chk("w52_sat_data", 64'(out_data2), 64'h0007_FFFF_FFFF_FFFF);
    chk("w52_sat_flag", 64'(sat_flag2), 64'd1);
`else
    chk("w52_wrap_data", 64'(out_data2), 64'h000F_FFFF_FFFF_FFFE);
`endif
    out_ready2 = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    out_ready2 = 1'b0;
    chk("w52_done", 64'(done2), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the fusion-unit array top.
- Consumes one registered row of per-column partial sums per beat and accumulates a programmable number of beats (passes over the K dimension) into wide per-column accumulators.
- Once the last pass lands, drains the finished column sums one per cycle over a valid/ready stream to the output buffer.
- Stalls the array feed (psum_ready low) while draining.

Parameters:
- ARRAY_SIZE, 16, number of array columns and accumulator lanes.
- COL_WIDTH, 13, per-fusion-unit column width; the input psum per column is COL_WIDTH*4 bits, two's complement.
- ACC_WIDTH, 64, accumulator and output width; must be >= COL_WIDTH*4.
- PASS_W, 8, width of the pass-count configuration.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a tile; honoured only in IDLE.
- cfg_passes  input  PASS_W  beats to accumulate; sampled on an honoured start; 0 is treated as 1.
- psum_valid  input  1  input beat valid.
- psum_ready  output  1  input beat accepted when psum_valid && psum_ready.
- psums  input  ARRAY_SIZE*COL_WIDTH*4  packed column psums; column i occupies bits [i*COL_WIDTH*4 +: COL_WIDTH*4].
- out_valid  output  1  drained result valid.
- out_ready  input  1  downstream accept.
- out_data  output  ACC_WIDTH  accumulated sum of column out_col, signed.
- out_col  output  $clog2(ARRAY_SIZE)  column index of out_data.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the last column is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all accumulators=0, pass_cnt=0, col_idx=0. Outputs: psum_ready=0, out_valid=0, out_data=0, out_col=0, busy=0, done=0.
- Reset asserted mid-tile aborts the tile; no partial output is emitted.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - psum_ready=0; psum_valid is ignored.
  - On start: latch passes_q=max(cfg_passes,1), clear pass_cnt, go to ACCUM next cycle.
- ACCUM:
  - psum_ready=1 combinationally, independent of psum_valid.
  - Each accepted beat sign-extends each column psum to ACC_WIDTH.
  - On the first beat (pass_cnt==0), acc[i] is loaded with the extended psum. This is a load, not an add, so no explicit clear is needed between tiles.
  - On later beats, acc[i] += extended psum, with two's-complement wrap.
  - pass_cnt increments on every accepted beat. When the accepted beat makes pass_cnt==passes_q, go to DRAIN with col_idx=0.
  - Cycles with psum_valid=0 hold all state.
- DRAIN:
  - psum_ready=0.
  - out_valid=1, out_data=acc[col_idx], out_col=col_idx. All three are driven from registers/mux and stay stable while out_ready=0.
  - On out_valid&&out_ready: col_idx++.
  - When the accepted column is ARRAY_SIZE-1: go to IDLE and pulse done=1 in the following cycle.
- Latency: last input beat accepted at edge N gives out_valid=1 in cycle N+1. A tile of P passes takes P accepted beats + ARRAY_SIZE accepted outputs. Minimum back-to-back tile spacing is 1 IDLE cycle.
- start outside IDLE is ignored. A start in the same cycle as the done pulse (state already IDLE) is honoured.
- out_ready held low stalls indefinitely without data loss.

Optional Feature:
- Macro: PSUM_ACC_SAT_EN.
- Defined: every accumulate saturates to the signed ACC_WIDTH range, [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. A per-tile sticky sat_flag output (1 bit, cleared on an honoured start) reports any lane clipping.
- Undefined: plain modular wrap, and the sat_flag port does not exist.

Decomposition:
- Shared package bf_pkg:
  - acc_state_t enum {IDLE, ACCUM, DRAIN}.
  - Localparams PSUM_W=COL_WIDTH*4 and COL_IDX_W.
  - A sign-extend function.
- One natural sub-module, psum_acc_lane: a single-lane register with load/add/saturate and an overflow output, instantiated ARRAY_SIZE times by generate.

Test Plan (ARRAY_SIZE=4, COL_WIDTH=13, ACC_WIDTH=64):
- Reset mid-DRAIN: pulse rst_n low -> out_valid=0, busy=0, state IDLE immediately (async). The next tile starts cleanly, with no stale accumulator contribution.
- Single pass: start, cfg_passes=1, beat psums={4,3,2,1} (col0=1) -> outputs col0..3 = 1,2,3,4 in order on consecutive cycles with out_ready=1. done pulses once, and busy falls in the same cycle as done.
- Multi-pass signed: cfg_passes=3, col0 beats {5,-7,100} -> col0 output 98. A column with beats of -(2^51) three times gives -3*2^51 with no wrap.
- cfg_passes=0: behaves exactly as 1 pass. psum_valid gaps of 2 cycles between beats -> identical results, psum_ready stays 1 throughout ACCUM.
- Back-pressure: out_ready low for 5 cycles on col2 -> out_data/out_col hold at col2's value, psum_ready=0. A start pulsed during DRAIN is ignored.
- PSUM_ACC_SAT_EN with ACC_WIDTH=52: two beats of 2^51-1 -> saturates to 2^51-1, sat_flag=1. With the macro undefined, the result wraps to -2.
